wave_capture: RTL and testbench

- Downstream consumer of the waveform generator's 32-bit `wave` output.
- Decimates the sample stream, waits for an optional rising-level trigger, and stores samples into a small FIFO.
- The CPU reads the FIFO over the PicoSoC iomem-style bus (valid/ready, wstrb, addr, wdata, rdata).
- Used for on-chip self-check of generated waveforms.

---
 rtl/wave_capture_pkg.sv | 36 +++
 rtl/wave_capture_fifo.sv | 74 +++++++
 rtl/wave_capture.sv | 202 ++++++++++++++++++++
 tb/tb_wave_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_pkg.sv
// Shared definitions for wave_capture: FSM states, register offsets, status bit
// positions and the byte-strobe merge helper.
package wave_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL  = 2'b00;
  localparam logic [1:0] REG_DECIM = 2'b01;
  localparam logic [1:0] REG_LEVEL = 2'b10;
  localparam logic [1:0] REG_DATA  = 2'b11;

  localparam int ST_BIT_DONE  = 0;
  localparam int ST_BIT_EMPTY = 1;
  localparam int ST_BIT_FULL  = 2;
  localparam int ST_BIT_OVF   = 3;
  localparam int ST_BIT_COUNT = 16;

  localparam int CTRL_BIT_ARM   = 0;
  localparam int CTRL_BIT_CLEAR = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wave_capture_fifo.sv
// Circular sample buffer with synchronous write and register-held read data;
// clr empties it synchronously, pushes when full and pops when empty are dropped.
module wave_capture_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [DATA_W-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full      = (count_r == DEPTH_C);
  assign empty     = (count_r == {(DEPTH_LOG2+1){1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full && !clr;
  assign pop_ok_s  = pop && !empty && !clr;

  // Sample storage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap modulo depth; count tracks occupancy including simultaneous push/pop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else if (clr) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Decimating waveform capture into a FIFO, read over an iomem-style bus.
// Define WAVE_CAPTURE_TRIG_EN to add the rising-level trigger and LEVEL register.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] wave_in,
  input  logic              valid,
  output logic              ready,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              irq
);

  localparam logic [DEPTH_LOG2:0] LAST_C = (DEPTH_LOG2+1)'((1 << DEPTH_LOG2) - 1);
`ifdef WAVE_CAPTURE_TRIG_EN
  localparam state_t ARM_STATE = ARMED;
`else
  localparam state_t ARM_STATE = CAPTURE;
`endif

  state_t              state_r, state_nx;
  logic [31:0]         cnt_r, cnt_nx;
  logic [31:0]         decim_r;
  logic [31:0]         rdata_r;
  logic [31:0]         status_s, rd_val_s;
  logic                ready_r, pop_pend_r, overflow_r, overflow_nx, irq_r;
  logic [DATA_W-1:0]   level_s, fifo_dout_s;
  logic [DEPTH_LOG2:0] fifo_count_s;
  logic                fifo_full_s, fifo_empty_s;
  logic [1:0]          sel_s;
  logic                req_s, acc_s, wr_s, rd_req_s, arm_s, clr_s, pop_s;
  logic                trig_s, push_req_s, fill_s, decim_hit_s;
  logic                addr_unused_s;

  assign sel_s         = addr[3:2];
  assign addr_unused_s = ^{addr[31:4], addr[1:0]};
  assign req_s         = valid && !ready_r;
  assign acc_s         = valid && ready_r;
  assign wr_s          = acc_s && (wstrb != 4'b0000);
  assign rd_req_s      = req_s && (wstrb == 4'b0000);
  assign arm_s         = wr_s && (sel_s == REG_CTRL) && wstrb[0] && wdata[CTRL_BIT_ARM];
  assign clr_s         = wr_s && (sel_s == REG_CTRL) && wstrb[0] && wdata[CTRL_BIT_CLEAR];
  assign pop_s         = acc_s && pop_pend_r;
  assign decim_hit_s   = (cnt_r == decim_r);
  // A push that fills the buffer, or one that is dropped because it is already full, ends capture
  assign fill_s        = fifo_full_s || ((fifo_count_s == LAST_C) && !pop_s);

`ifdef WAVE_CAPTURE_TRIG_EN
  logic [DATA_W-1:0] level_r, prev_r;

  // LEVEL register and previous sample for rising-crossing detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level_r <= {DATA_W{1'b0}};
      prev_r  <= {DATA_W{1'b0}};
    end else begin
      prev_r <= wave_in;
      if (wr_s && (sel_s == REG_LEVEL)) begin
        level_r <= DATA_W'(merge_bytes(32'(level_r), wdata, wstrb));
      end
    end
  end

  assign level_s = level_r;
  assign trig_s  = (prev_r < level_r) && (wave_in >= level_r);
`else
  assign level_s = {DATA_W{1'b0}};
  assign trig_s  = 1'b0;
`endif

  // DECIM register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      decim_r <= 32'h0;
    end else if (wr_s && (sel_s == REG_DECIM)) begin
      decim_r <= merge_bytes(decim_r, wdata, wstrb);
    end
  end

  // Capture FSM next state, decimation counter and push request
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    push_req_s = 1'b0;
    if (clr_s) begin
      state_nx = IDLE;
      cnt_nx   = 32'h0;
    end else if (arm_s) begin
      state_nx = ARM_STATE;
      cnt_nx   = 32'h0;
    end else begin
      case (state_r)
        ARMED: begin
          if (trig_s) begin
            push_req_s = 1'b1;
            cnt_nx     = 32'h0;
            state_nx   = fill_s ? DONE : CAPTURE;
          end else begin
            cnt_nx = 32'h0;
          end
        end
        CAPTURE: begin
          if (decim_hit_s) begin
            push_req_s = 1'b1;
            cnt_nx     = 32'h0;
            state_nx   = fill_s ? DONE : CAPTURE;
          end else begin
            cnt_nx = cnt_r + 32'd1;
          end
        end
        default: begin
          state_nx = state_r;
        end
      endcase
    end
  end

  // Sticky overflow flag
  always_comb begin
    overflow_nx = overflow_r;
    if (clr_s) begin
      overflow_nx = 1'b0;
    end else if (push_req_s && fifo_full_s) begin
      overflow_nx = 1'b1;
    end else begin
      overflow_nx = overflow_r;
    end
  end

  // FSM state, counter, overflow and irq registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      cnt_r      <= 32'h0;
      overflow_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      state_r    <= state_nx;
      cnt_r      <= cnt_nx;
      overflow_r <= overflow_nx;
      irq_r      <= (state_nx == DONE);
    end
  end

  // Status word and read-data mux, evaluated when the request is first seen
  always_comb begin
    status_s                                  = 32'h0;
    status_s[ST_BIT_COUNT +: (DEPTH_LOG2+1)]  = fifo_count_s;
    status_s[ST_BIT_OVF]                      = overflow_r;
    status_s[ST_BIT_FULL]                     = fifo_full_s;
    status_s[ST_BIT_EMPTY]                    = fifo_empty_s;
    status_s[ST_BIT_DONE]                     = (state_r == DONE);
    case (sel_s)
      REG_CTRL:  rd_val_s = status_s;
      REG_DECIM: rd_val_s = decim_r;
      REG_LEVEL: rd_val_s = 32'(level_s);
      REG_DATA:  rd_val_s = fifo_empty_s ? 32'h0 : 32'(fifo_dout_s);
      default:   rd_val_s = 32'h0;
    endcase
  end

  // Bus handshake; a DATA pop is committed in the ready cycle only if data was returned
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_r    <= 1'b0;
      rdata_r    <= 32'h0;
      pop_pend_r <= 1'b0;
    end else begin
      ready_r    <= req_s;
      rdata_r    <= rd_req_s ? rd_val_s : 32'h0;
      pop_pend_r <= rd_req_s && (sel_s == REG_DATA) && !fifo_empty_s;
    end
  end

  wave_capture_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr_s),
    .push   (push_req_s),
    .pop    (pop_s),
    .din    (wave_in),
    .dout   (fifo_dout_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s),
    .count  (fifo_count_s)
  );

  assign ready = ready_r;
  assign rdata = rdata_r;
  assign irq   = irq_r;

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture; expectations follow the
// trigger option (WAVE_CAPTURE_TRIG_EN) selected at compile time.
module tb_wave_capture;

  localparam logic [1:0] R_CTRL  = 2'd0;
  localparam logic [1:0] R_DECIM = 2'd1;
  localparam logic [1:0] R_LEVEL = 2'd2;
  localparam logic [1:0] R_DATA  = 2'd3;
`ifdef WAVE_CAPTURE_TRIG_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif
  // Cycles from ARM completion until a read request lands its pop on the 8th push
  localparam int POP_WAIT = TRIG ? 13 : 14;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] wave_in;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  logic        ramp_en;
  logic [31:0] ramp_load;
  logic [31:0] q;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  wave_capture dut (
    .clk     (clk),
    .resetn  (resetn),
    .wave_in (wave_in),
    .valid   (valid),
    .ready   (ready),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  // Ramp source: +10 per cycle when enabled, else held at ramp_load; changes on negedge
  initial begin
    wave_in = 32'd0;
    forever begin
      @(negedge clk);
      if (ramp_en) wave_in = wave_in + 32'd10;
      else         wave_in = ramp_load;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic [1:0] r, input logic [3:0] strb,
                          input logic [31:0] d, output logic [31:0] rd);
    int n;
    valid = 1'b1;
    wstrb = strb;
    addr  = {28'h0, r, 2'b00};
    wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready && n < 8);
    rd = rdata;
    check("bus_ready", 32'(ready), 32'h1);
    @(posedge clk);
    #1;
    check("ready_pulse", 32'(ready), 32'h0);
    valid = 1'b0;
    wstrb = 4'h0;
    wdata = 32'h0;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(r, 4'hf, d, dummy);
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] v);
    bus_xfer(r, 4'h0, 32'h0, v);
  endtask

  task automatic wait_irq(input int max);
    int n;
    n = 0;
    while (!irq && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("irq_done", 32'(irq), 32'h1);
  endtask

  // Clear, configure, hold the ramp at 0, ARM, then start the ramp right after ARM completes
  task automatic start_capture(input logic [31:0] decim, input logic [31:0] level);
    ramp_en   = 1'b0;
    ramp_load = 32'd0;
    wr(R_CTRL, 32'h2);
    wr(R_DECIM, decim);
    wr(R_LEVEL, level);
    wr(R_CTRL, 32'h1);
    ramp_en = 1'b1;
  endtask

  initial begin
    resetn    = 1'b0;
    valid     = 1'b0;
    wstrb     = 4'h0;
    addr      = 32'h0;
    wdata     = 32'h0;
    ramp_en   = 1'b0;
    ramp_load = 32'd0;
    n_checks  = 0;
    n_fail    = 0;

    cycles(3);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    resetn = 1'b1;
    cycles(1);
    rd(R_CTRL, q);  check("rst_status", q, 32'h2);
    rd(R_DECIM, q); check("rst_decim", q, 32'h0);
    rd(R_LEVEL, q); check("rst_level", q, 32'h0);
    rd(R_DATA, q);  check("rst_data_empty", q, 32'h0);

    wr(R_DECIM, 32'd7);
    rd(R_DECIM, q); check("decim_rw", q, 32'd7);
    wr(R_LEVEL, 32'd55);
    rd(R_LEVEL, q); check("level_rw", q, TRIG ? 32'd55 : 32'd0);

    // DECIM=0 fill to 16
    start_capture(32'd0, 32'd100);
    check("irq_armed", 32'(irq), 32'h0);
    wait_irq(200);
    rd(R_CTRL, q); check("full_status", q, 32'h0010_0005);

    // Re-ARM while full: one dropped push sets overflow, back to DONE
    ramp_en = 1'b0;
    cycles(2);
    wr(R_CTRL, 32'h1);
    ramp_en = 1'b1;
    cycles(40);
    check("ovf_irq", 32'(irq), 32'h1);
    rd(R_CTRL, q); check("ovf_status", q, 32'h0010_000D);
    for (int i = 0; i < 16; i++) begin
      rd(R_DATA, q);
      check($sformatf("d0_data%0d", i), q, (TRIG ? 32'd100 : 32'd10) + 32'(10 * i));
    end
    rd(R_CTRL, q); check("drained_status", q, 32'h0000_000B);
    wr(R_CTRL, 32'h2);
    check("clear_irq", 32'(irq), 32'h0);
    rd(R_CTRL, q); check("clear_status", q, 32'h2);

    // CLEAR wins over ARM in the same write
    wr(R_CTRL, 32'h3);
    cycles(10);
    rd(R_CTRL, q); check("clr_prio_status", q, 32'h2);

    // DECIM=3: samples 4 cycles apart
    start_capture(32'd3, 32'd100);
    wait_irq(300);
    for (int i = 0; i < 16; i++) begin
      rd(R_DATA, q);
      check($sformatf("d3_data%0d", i), q, (TRIG ? 32'd100 : 32'd40) + 32'(40 * i));
    end

    // Pop lands on the same edge as the 8th push (count 7 before)
    start_capture(32'd1, 32'd1);
    repeat (POP_WAIT) @(posedge clk);
    #1;
    rd(R_DATA, q); check("pp_oldest", q, TRIG ? 32'd10 : 32'd20);
    rd(R_CTRL, q); check("pp_count7", q, 32'h0007_0000);
    rd(R_DATA, q); check("pp_second", q, TRIG ? 32'd30 : 32'd40);

    // Reset in the middle of a capture
    start_capture(32'd3, 32'd100);
    cycles(27);
    resetn = 1'b0;
    #1;
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_ready", 32'(ready), 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    cycles(2);
    resetn = 1'b1;
    cycles(1);
    rd(R_CTRL, q);  check("mid_rst_status", q, 32'h2);
    rd(R_DATA, q);  check("mid_rst_data", q, 32'h0);
    rd(R_DECIM, q); check("mid_rst_decim", q, 32'h0);
    check("mid_rst_irq_after", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
